// File: rtl/agc_normalizer_if.sv
// Sample stream into and out of the AGC: complex input with strobe,
// scaled complex output with strobe.
interface agc_normalizer_if #(
   parameter int DATA_WIDTH = 16
);
   logic signed [DATA_WIDTH-1:0] data_in_real;
   logic signed [DATA_WIDTH-1:0] data_in_imag;
   logic                         data_valid;
   logic signed [DATA_WIDTH-1:0] data_out_real;
   logic signed [DATA_WIDTH-1:0] data_out_imag;
   logic                         data_out_valid;

   modport master (
      output data_in_real, data_in_imag, data_valid,
      input  data_out_real, data_out_imag, data_out_valid
   );

   modport slave (
      input  data_in_real, data_in_imag, data_valid,
      output data_out_real, data_out_imag, data_out_valid
   );
endinterface

// File: rtl/agc_normalizer.sv
// Feedback AGC ahead of the CMA equalizer: windowed power estimate driving a
// two-speed (ACQUIRE/TRACK) gain loop. Statistics outputs built only with AGC_STATS_EN.
module agc_normalizer #(
   parameter int DATA_WIDTH    = 16,
   parameter int FRAC_BITS     = 12,
   parameter int GAIN_W        = 16,
   parameter int INIT_GAIN     = 4096,
   parameter int GAIN_MIN      = 256,
   parameter int GAIN_MAX      = 65535,
   parameter int LOG2_WIN      = 6,
   parameter int TARGET_POWER  = 1 << 24,
   parameter int ACQ_SHIFT     = 14,
   parameter int TRK_SHIFT     = 18,
   parameter int LOCK_THRESH   = 1 << 20,
   parameter int LOCK_WINDOWS  = 4,
   parameter int UNLOCK_THRESH = 1 << 22
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   agc_normalizer_if.slave       stream,
   output logic [GAIN_W-1:0]     gain,
   output logic                  locked,
   output logic [15:0]           sat_count,
   output logic [2*DATA_WIDTH:0] window_power
);
   localparam int PROD_W = DATA_WIDTH + GAIN_W + 1;
   localparam int PWR_W  = 2 * DATA_WIDTH + 1;
   localparam int ACC_W  = PWR_W + LOG2_WIN;
   localparam int ERR_W  = ACC_W + 2;
   localparam int LCNT_W = $clog2(LOCK_WINDOWS + 1);
   localparam logic signed [PROD_W-1:0] Y_MAX = PROD_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [PROD_W-1:0] Y_MIN = ~Y_MAX;

   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_t;

   // Full-precision x*gain already shifted back to Q(FRAC_BITS), before saturation.
   function automatic logic signed [PROD_W-1:0] scaled_wide(
      input logic signed [DATA_WIDTH-1:0] x, input logic [GAIN_W-1:0] g);
      logic signed [PROD_W-1:0] xe;
      logic signed [PROD_W-1:0] ge;
      xe = {{(PROD_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
      ge = {{(PROD_W-GAIN_W){1'b0}}, g};
      return (xe * ge) >>> FRAC_BITS;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat_rail(input logic signed [PROD_W-1:0] w);
      if (w > Y_MAX)      return Y_MAX[DATA_WIDTH-1:0];
      else if (w < Y_MIN) return Y_MIN[DATA_WIDTH-1:0];
      else                return w[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [PWR_W-1:0] power_of(
      input logic signed [DATA_WIDTH-1:0] a, input logic signed [DATA_WIDTH-1:0] b);
      logic signed [PWR_W-1:0] ae;
      logic signed [PWR_W-1:0] be;
      ae = {{(PWR_W-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
      be = {{(PWR_W-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
      return $unsigned(ae * ae + be * be);
   endfunction

   state_t                   state_r, state_next_s;
   logic [LCNT_W-1:0]        lock_cnt_r, lock_cnt_next_s;
   logic [ACC_W-1:0]         acc_r, acc_sum_s;
   logic [LOG2_WIN-1:0]      win_cnt_r;
   logic signed [PROD_W-1:0] wide_r_s, wide_i_s;
   logic [PWR_W-1:0]         power_s, avg_s;
   logic                     accept_s, close_s;
   logic signed [ERR_W-1:0]  err_s, abs_err_s, step_s, gain_sum_s;
   logic [GAIN_W-1:0]        gain_next_s;

   assign accept_s = enable && stream.data_valid;
   assign wide_r_s = scaled_wide(stream.data_in_real, gain);
   assign wide_i_s = scaled_wide(stream.data_in_imag, gain);
   assign power_s  = power_of(stream.data_out_real, stream.data_out_imag);

   // Window-close arithmetic: mean power, error, shifted step and clamped new gain.
   always_comb begin
      acc_sum_s = acc_r + {{LOG2_WIN{1'b0}}, power_s};
      close_s   = enable && stream.data_out_valid && (&win_cnt_r);
      avg_s     = acc_sum_s[ACC_W-1:LOG2_WIN];
      err_s     = $signed(ERR_W'(TARGET_POWER)) - $signed({{(ERR_W-PWR_W){1'b0}}, avg_s});
      abs_err_s = err_s[ERR_W-1] ? -err_s : err_s;
      if (state_r == TRACK) begin
         step_s = err_s >>> TRK_SHIFT;
      end else begin
         step_s = err_s >>> ACQ_SHIFT;
      end
      gain_sum_s = $signed({{(ERR_W-GAIN_W){1'b0}}, gain}) + step_s;
      if (gain_sum_s < $signed(ERR_W'(GAIN_MIN))) begin
         gain_next_s = GAIN_W'(GAIN_MIN);
      end else if (gain_sum_s > $signed(ERR_W'(GAIN_MAX))) begin
         gain_next_s = GAIN_W'(GAIN_MAX);
      end else begin
         gain_next_s = gain_sum_s[GAIN_W-1:0];
      end
   end

   // Loop state: lock is earned over consecutive quiet windows, lost on one loud window.
   always_comb begin
      state_next_s    = state_r;
      lock_cnt_next_s = lock_cnt_r;
      if (!enable) begin
         state_next_s    = IDLE;
         lock_cnt_next_s = '0;
      end else begin
         case (state_r)
            IDLE: state_next_s = ACQUIRE;
            ACQUIRE: begin
               if (!close_s) begin
                  lock_cnt_next_s = lock_cnt_r;
               end else if (abs_err_s < $signed(ERR_W'(LOCK_THRESH))) begin
                  if (lock_cnt_r == LCNT_W'(LOCK_WINDOWS - 1)) begin
                     state_next_s    = TRACK;
                     lock_cnt_next_s = '0;
                  end else begin
                     lock_cnt_next_s = lock_cnt_r + LCNT_W'(1);
                  end
               end else begin
                  lock_cnt_next_s = '0;
               end
            end
            TRACK: begin
               if (close_s && (abs_err_s > $signed(ERR_W'(UNLOCK_THRESH)))) begin
                  state_next_s    = ACQUIRE;
                  lock_cnt_next_s = '0;
               end else begin
                  state_next_s = TRACK;
               end
            end
            default: begin
               state_next_s    = IDLE;
               lock_cnt_next_s = '0;
            end
         endcase
      end
   end

   // Scaled output register; the gain used is the one in place at the sampling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream.data_out_real  <= '0;
         stream.data_out_imag  <= '0;
         stream.data_out_valid <= 1'b0;
      end else if (accept_s) begin
         stream.data_out_real  <= sat_rail(wide_r_s);
         stream.data_out_imag  <= sat_rail(wide_i_s);
         stream.data_out_valid <= 1'b1;
      end else begin
         stream.data_out_valid <= 1'b0;
      end
   end

   // Power accumulation, window counting and gain update; enable low discards the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain       <= GAIN_W'(INIT_GAIN);
         acc_r      <= '0;
         win_cnt_r  <= '0;
         state_r    <= IDLE;
         lock_cnt_r <= '0;
         locked     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         lock_cnt_r <= lock_cnt_next_s;
         locked     <= (state_next_s == TRACK);
         if (!enable) begin
            acc_r     <= '0;
            win_cnt_r <= '0;
         end else if (stream.data_out_valid) begin
            if (close_s) begin
               acc_r     <= '0;
               win_cnt_r <= '0;
               gain      <= gain_next_s;
            end else begin
               acc_r     <= acc_sum_s;
               win_cnt_r <= win_cnt_r + LOG2_WIN'(1);
            end
         end
      end
   end

`ifdef AGC_STATS_EN
   function automatic logic rail_overflows(input logic signed [PROD_W-1:0] w);
      return (w > Y_MAX) || (w < Y_MIN);
   endfunction

   logic sat_hit_s;
   assign sat_hit_s = rail_overflows(wide_r_s) || rail_overflows(wide_i_s);

   // Saturated-sample counter, sticky at full scale, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= 16'd0;
      end else if (accept_s && sat_hit_s && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

   // Mean power of the most recently closed window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_power <= '0;
      end else if (close_s) begin
         window_power <= avg_s;
      end
   end
`else
   assign sat_count    = 16'd0;
   assign window_power = '0;
`endif
endmodule

// File: tb/tb_agc_normalizer.sv
// Randomised + directed bench for agc_normalizer with a queue scoreboard fed by
// an arithmetic reference model of the gain loop.
module tb_agc_normalizer;
   localparam longint TARGET = 64'd1 << 24;
   localparam longint LOCK_T = 64'd1 << 20;
   localparam longint UNLK_T = 64'd1 << 22;
   localparam int ST_IDLE = 0, ST_ACQ = 1, ST_TRACK = 2;

   typedef struct {
      longint yr; longint yi; longint g; longint lk; longint satc; longint wp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] gain;
   logic        locked;
   logic [15:0] sat_count;
   logic [32:0] window_power;

   agc_normalizer_if #(.DATA_WIDTH(16)) bus ();

   agc_normalizer dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stream(bus.slave),
      .gain(gain), .locked(locked), .sat_count(sat_count), .window_power(window_power)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   exp_t q[$];

   // reference model state
   longint m_gain, m_acc, m_wp, pend_p;
   int     m_cnt, m_lockc, m_state, m_satc;
   bit     pend_v;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic longint scale(input longint x, input longint g, output bit s);
      longint v;
      v = (x * g) >>> 12;
      s = 1'b0;
      if (v > 32767) begin v = 32767; s = 1'b1; end
      else if (v < -32768) begin v = -32768; s = 1'b1; end
      return v;
   endfunction

   task automatic model_reset();
      m_gain = 4096; m_acc = 0; m_wp = 0; m_cnt = 0; m_lockc = 0;
      m_state = ST_IDLE; m_satc = 0; pend_v = 1'b0; pend_p = 0;
      q.delete();
   endtask

   // One clock edge of the loop as described by its rules: sample with the
   // current gain, then fold the previous output into the window.
   task automatic model_edge(input bit en, input bit dv, input int xr, input int xi);
      exp_t e;
      bit sr, si, new_v;
      longint yr, yi, avg, err, ae, ng;
      new_v = 1'b0; yr = 0; yi = 0;
      if (!en) begin
         pend_v = 1'b0; m_acc = 0; m_cnt = 0; m_lockc = 0; m_state = ST_IDLE;
      end else begin
         if (dv) begin
            yr = scale(xr, m_gain, sr);
            yi = scale(xi, m_gain, si);
            new_v = 1'b1;
            if ((sr || si) && m_satc < 65535) m_satc++;
         end
         if (pend_v) begin
            m_acc += pend_p;
            m_cnt++;
            if (m_cnt == 64) begin
               avg = m_acc / 64;
               err = TARGET - avg;
               ae  = (err < 0) ? -err : err;
               ng  = m_gain + (err >>> ((m_state == ST_TRACK) ? 18 : 14));
               m_gain = (ng < 256) ? 256 : (ng > 65535) ? 65535 : ng;
               m_wp = avg;
               if (m_state == ST_TRACK) begin
                  if (ae > UNLK_T) begin m_state = ST_ACQ; m_lockc = 0; end
               end else if (ae < LOCK_T) begin
                  m_lockc++;
                  if (m_lockc >= 4) begin m_state = ST_TRACK; m_lockc = 0; end
               end else begin
                  m_lockc = 0;
               end
               m_acc = 0; m_cnt = 0;
            end
         end
         if (m_state == ST_IDLE) m_state = ST_ACQ;
         pend_v = new_v;
         pend_p = yr * yr + yi * yi;
      end
      if (new_v) begin
         e.yr = yr; e.yi = yi; e.g = m_gain; e.lk = (m_state == ST_TRACK) ? 1 : 0;
         e.satc = m_satc; e.wp = m_wp;
         q.push_back(e);
      end
   endtask

   task automatic cyc(input bit en, input bit dv, input int xr, input int xi);
      @(negedge clk);
      enable = en;
      bus.data_valid = dv;
      bus.data_in_real = 16'(xr);
      bus.data_in_imag = 16'(xi);
      model_edge(en, dv, xr, xi);
   endtask

   task automatic run(input int n, input int xr, input int xi);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, xr, xi);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0; bus.data_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_gain", gain, 4096);
      check("rst_locked", locked, 0);
      check("rst_valid", bus.data_out_valid, 0);
      check("rst_out_real", bus.data_out_real, 0);
      check("rst_out_imag", bus.data_out_imag, 0);
      check("rst_sat_count", sat_count, 0);
      check("rst_window_power", window_power, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: every DUT output strobe is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.data_out_valid) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output: got valid=1, expected no output");
            end else begin
               e = q.pop_front();
               check("y_real", longint'($signed(bus.data_out_real)), e.yr);
               check("y_imag", longint'($signed(bus.data_out_imag)), e.yi);
               check("gain", gain, e.g);
               check("locked", locked, e.lk);
`ifdef AGC_STATS_EN
               check("sat_count", sat_count, e.satc);
               check("window_power", window_power, e.wp);
`else
               check("sat_count", sat_count, 0);
               check("window_power", window_power, 0);
`endif
            end
         end
      end
   end

   initial begin
      longint g_hold;
      int xr, xi;
      bus.data_valid = 1'b0; bus.data_in_real = '0; bus.data_in_imag = '0;
      model_reset();
      #1 rst_n = 1'b0;
      do_reset();

      // unity gain pass-through, then reset in the middle of the window
      run(10, 1000, -500);
      idle(2);
      do_reset();

      // convergence from unity gain
      run(64, 2048, 0);
      idle(2);
      check("first_update_gain", gain, 4864);
      run(63 * 64, 2048, 0);
      idle(2);
      // TRACK steps vanish once |e| < 2^18, so gain settles a little under 8192
      check_range("converged_gain", gain, 8120, 8200);
      check("converged_locked", locked, 1);

      // saturation on both rails
      run(4, 32767, -32768);
      idle(2);
`ifdef AGC_STATS_EN
      check("sat_count_after_sat", sat_count, 4);
`else
      check("sat_count_after_sat", sat_count, 0);
`endif

      // enable drop mid-window: gain held, window restarts from zero
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b0, 0, 0);
      g_hold = m_gain;
      run(40, 2048, 0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0);
      check("hold_gain", gain, g_hold);
      check("hold_locked", locked, 0);
      run(63, 2048, 0);
      idle(2);
      check("no_early_update", gain, g_hold);
      run(1, 2048, 0);
      idle(2);
      check("fresh_window_update", gain, m_gain);

      // randomised traffic with gaps, enable drops and occasional full-scale bursts
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            xr = int'($urandom_range(0, 65535)) - 32768;
            xi = int'($urandom_range(0, 65535)) - 32768;
         end else begin
            xr = int'($urandom_range(0, 6000)) - 3000;
            xi = int'($urandom_range(0, 6000)) - 3000;
         end
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, xr, xi);
      end
      idle(2);
      do_reset();

      // zero input drives gain to the upper clamp, never locking
      run(62 * 64, 0, 0);
      idle(2);
      check("clamp_gain", gain, 65535);
      check("clamp_locked", locked, 0);

      idle(3);
      check("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
